// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine: one shift-add datapath reused for ITER micro-rotations,
// wrapped in a three-state controller with valid/ready handshakes on both sides.
module cordic_iter_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy,
    output logic [4:0]       iter_cnt,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The producer holds in_valid and its data until in_ready; results stay put until out_ready.

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    logic [1:0]       r_state;
    logic [4:0]       r_iter;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_x_out;
    logic [WIDTH-1:0] r_y_out;
    logic [WIDTH-1:0] r_z_out;

    logic             w_d;
    logic [WIDTH-1:0] w_x_sh;
    logic [WIDTH-1:0] w_y_sh;
    logic [WIDTH-1:0] w_atan;
    logic [WIDTH-1:0] w_x_nx;
    logic [WIDTH-1:0] w_y_nx;
    logic [WIDTH-1:0] w_z_nx;

    // round(atan(2^-i) * 2^29); from i=10 on the entry is the power of two 2^(29-i)
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:    v = 32'h1921FB54;
            5'd1:    v = 32'h0ED63383;
            5'd2:    v = 32'h07D6DD7E;
            5'd3:    v = 32'h03FAB753;
            5'd4:    v = 32'h01FF55BB;
            5'd5:    v = 32'h00FFEAAE;
            5'd6:    v = 32'h007FFD55;
            5'd7:    v = 32'h003FFFAB;
            5'd8:    v = 32'h001FFFF5;
            5'd9:    v = 32'h000FFFFF;
            5'd10:   v = 32'h00080000;
            5'd11:   v = 32'h00040000;
            5'd12:   v = 32'h00020000;
            5'd13:   v = 32'h00010000;
            5'd14:   v = 32'h00008000;
            5'd15:   v = 32'h00004000;
            5'd16:   v = 32'h00002000;
            5'd17:   v = 32'h00001000;
            5'd18:   v = 32'h00000800;
            5'd19:   v = 32'h00000400;
            5'd20:   v = 32'h00000200;
            5'd21:   v = 32'h00000100;
            5'd22:   v = 32'h00000080;
            5'd23:   v = 32'h00000040;
            5'd24:   v = 32'h00000020;
            5'd25:   v = 32'h00000010;
            5'd26:   v = 32'h00000008;
            5'd27:   v = 32'h00000004;
            5'd28:   v = 32'h00000002;
            5'd29:   v = 32'h00000001;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    always_comb begin
        // A zero residual angle rotates the negative way
        w_d    = !r_z[WIDTH-1] && (r_z != '0);
        w_x_sh = $signed(r_x) >>> r_iter;
        w_y_sh = $signed(r_y) >>> r_iter;
        w_atan = WIDTH'(atan_lut(r_iter));
        if (w_d) begin
            w_x_nx = r_x - w_y_sh;
            w_y_nx = r_y + w_x_sh;
            w_z_nx = r_z - w_atan;
        end else begin
            w_x_nx = r_x + w_y_sh;
            w_y_nx = r_y - w_x_sh;
            w_z_nx = r_z + w_atan;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_iter  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x     <= x_in;
                        r_y     <= y_in;
                        r_z     <= z_in;
                        r_iter  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_x <= w_x_nx;
                    r_y <= w_y_nx;
                    r_z <= w_z_nx;
                    if (r_iter == LAST_ITER) begin
                        r_x_out <= w_x_nx;
                        r_y_out <= w_y_nx;
                        r_z_out <= w_z_nx;
                        r_state <= ST_DONE;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign iter_cnt  = r_iter;
    assign x_out     = r_x_out;
    assign y_out     = r_y_out;
    assign z_out     = r_z_out;
    assign fsm_state = r_state;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: reset, latency, backpressure, back-to-back and abort,
// with results compared against an independent real-math atan table and integer CORDIC model.
module tb_cordic_iter_ctrl;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic [WIDTH-1:0] z_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] z_out;
    logic             busy;
    logic [4:0]       iter_cnt;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] atan_tab[32];
    logic [WIDTH-1:0] exp_x_q[$];
    logic [WIDTH-1:0] exp_y_q[$];
    logic [WIDTH-1:0] exp_z_q[$];

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy),
        .iter_cnt  (iter_cnt),
        .fsm_state (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic longint adiff(input logic [31:0] a, input logic [31:0] b);
        longint d;
        d = longint'($signed(a)) - longint'($signed(b));
        return (d < 0) ? -d : d;
    endfunction

    function automatic void model(input logic [31:0] xi, input logic [31:0] yi,
                                  input logic [31:0] zi, output logic [31:0] xo,
                                  output logic [31:0] yo, output logic [31:0] zo);
        logic signed [31:0] x, y, z, xs, ys;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            if (z > 0) begin
                x = x - ys; y = y + xs; z = z - atan_tab[i];
            end else begin
                x = x + ys; y = y - xs; z = z + atan_tab[i];
            end
        end
        xo = x; yo = y; zo = z;
    endfunction

    task automatic check_result(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                                input logic [31:0] zi);
        logic [31:0] ex, ey, ez;
        model(xi, yi, zi, ex, ey, ez);
        check({tag, "_x"}, x_out, ex);
        check({tag, "_y"}, y_out, ey);
        check({tag, "_z"}, z_out, ez);
    endtask

    // Present one vector from IDLE, step through every RUN cycle, stop in DONE with out_ready=0
    task automatic run_one(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                           input logic [31:0] zi);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x_in = xi; y_in = yi; z_in = zi;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        check({tag, "_busy_t0"}, 32'(busy), 32'd1);
        check({tag, "_iter_t0"}, 32'(iter_cnt), 32'd0);
        for (int k = 1; k <= ITER; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < ITER) begin
                check({tag, "_iter"}, 32'(iter_cnt), 32'(k));
                if (k == ITER - 1) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            end
        end
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        check_result(tag, xi, yi, zi);
    endtask

    task automatic release_done(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rel_busy"}, 32'(busy), 32'd0);
        check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_stream();
        logic [31:0] vx[3], vy[3], vz[3];
        logic [31:0] ex, ey, ez;
        logic acc, fire;
        int idx, got, cyc, last_acc;
        vx[0] = 32'h20000000; vy[0] = 32'h00000000; vz[0] = 32'h10000000;
        vx[1] = 32'h0C000000; vy[1] = 32'hF8000000; vz[1] = 32'hF0000000;
        vx[2] = 32'hE0000000; vy[2] = 32'h10000000; vz[2] = 32'h00000000;
        idx = 0; got = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        while (got < 3 && cyc < 200) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                x_in = vx[idx]; y_in = vy[idx]; z_in = vz[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                check("b2b_queue", 32'(exp_x_q.size() > 0), 32'd1);
                if (exp_x_q.size() > 0) begin
                    check("b2b_x", x_out, exp_x_q.pop_front());
                    check("b2b_y", y_out, exp_y_q.pop_front());
                    check("b2b_z", z_out, exp_z_q.pop_front());
                end
                got++;
            end
            @(posedge clk);
            cyc++;
            if (acc) begin
                model(vx[idx], vy[idx], vz[idx], ex, ey, ez);
                exp_x_q.push_back(ex);
                exp_y_q.push_back(ey);
                exp_z_q.push_back(ez);
                if (last_acc >= 0) check("b2b_gap", 32'(cyc - last_acc), 32'(ITER + 2));
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_done_count", 32'(got), 32'd3);
    endtask

    initial begin
        real p;
        p = 1.0;
        for (int i = 0; i < 32; i++) atan_tab[i] = 32'h0;
        for (int i = 0; i < ITER; i++) begin
            atan_tab[i] = 32'(longint'($atan(p) * 536870912.0));
            p = p / 2.0;
        end

        // Reset held two cycles with a vector offered: nothing may be captured
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        x_in = 32'h12345678; y_in = 32'h0BADF00D; z_in = 32'h01000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_iter", 32'(iter_cnt), 32'd0);
        check("rst_x_out", x_out, 32'd0);
        check("rst_y_out", y_out, 32'd0);
        check("rst_z_out", z_out, 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Gain check: 1/K on the x axis comes back as ~1.0
        run_one("gain", 32'h136E9DB5, 32'h0, 32'h0);
        check("gain_x_near", 32'(adiff(x_out, 32'h20000000) <= 256), 32'd1);
        check("gain_y_near", 32'(adiff(y_out, 32'h0) <= 32768), 32'd1);
        check("gain_z_near", 32'(adiff(z_out, 32'h0) <= 32768), 32'd1);

        // Backpressure: ten cycles of out_ready=0 in DONE
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check_result("bp_hold", 32'h136E9DB5, 32'h0, 32'h0);
        end
        release_done("gain");

        // pi/4 rotation of a unit vector
        run_one("pi4", 32'h136E9DB5, 32'h0, 32'h1921FB54);
        check("pi4_x_near", 32'(adiff(x_out, 32'h16A09E66) <= 32768), 32'd1);
        check("pi4_y_near", 32'(adiff(y_out, 32'h16A09E66) <= 32768), 32'd1);
        check("pi4_z_near", 32'(adiff(z_out, 32'h0) <= 32768), 32'd1);
        release_done("pi4");

        run_stream();

        // Abort mid-run at iteration 7
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        x_in = 32'h0AAAAAAA; y_in = 32'h05555555; z_in = 32'hF3000000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (iter_cnt != 5'd7 && guard < 40) begin
                @(posedge clk);
                @(negedge clk);
                guard++;
            end
            check("abort_reach_iter7", 32'(iter_cnt), 32'd7);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_iter", 32'(iter_cnt), 32'd0);
        check("abort_x_out", x_out, 32'd0);
        check("abort_y_out", y_out, 32'd0);
        check("abort_z_out", z_out, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);

        run_one("post_abort", 32'h18000000, 32'hFC000000, 32'h0C000000);
        release_done("post_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
